// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-wide full-adder slice plus a registered carry,
// processing WIDTH/DIGIT digits per operation behind a start/ready/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    typedef enum logic {StIdle, StRun} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [WIDTH-1:0]   acc_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [DIGIT:0]     slice;
    logic [DIGIT-1:0]   dig_a;
    logic [DIGIT-1:0]   dig_b;
    logic [DIGIT-1:0]   dig_sum;
    logic               slice_co;
    logic               msb_cin;
    logic               last;
    logic [WIDTH-1:0]   acc_next;

    always_comb begin
        dig_a    = op_a_q[DIGIT-1:0];
        dig_b    = op_b_q[DIGIT-1:0];
        slice    = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
        dig_sum  = slice[DIGIT-1:0];
        slice_co = slice[DIGIT];
        // Carry into the top bit of the slice, recovered from that bit's sum.
        msb_cin  = dig_sum[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];
        acc_next = (acc_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
        last     = (cnt_q == CNT_W'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            co      <= 1'b0;
            ov      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_a_q  <= a;
                        op_b_q  <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= StRun;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                StRun: begin
                    op_a_q  <= op_a_q >> DIGIT;
                    op_b_q  <= op_b_q >> DIGIT;
                    carry_q <= slice_co;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    acc_q   <= acc_next;
                    if (last) begin
                        s       <= acc_next;
                        co      <= slice_co;
                        ov      <= msb_cin ^ slice_co;
                        done    <= 1'b1;
                        state_q <= StIdle;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit
// instance, checked against a plain-arithmetic reference model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8, start16, sub;
    logic [15:0] a, b;

    logic        ready8, busy8, done8, co8, ov8;
    logic [7:0]  s8;
    logic        ready16, busy16, done16, co16, ov16;
    logic [15:0] s16;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .a(a[7:0]), .b(b[7:0]),
        .ready(ready8), .busy(busy8), .done(done8), .s(s8), .co(co8), .ov(ov8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub), .a(a), .b(b),
        .ready(ready16), .busy(busy16), .done(done16), .s(s16), .co(co16), .ov(ov16)
    );

    typedef struct {
        logic [17:0] exp;
        int          issue_cyc;
    } entry_t;

    entry_t q8[$];
    entry_t q16[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done8_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Returns {s[15:0], co, ov} from signed/unsigned integer arithmetic.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                                           input logic subv);
        longint mod, half, ua, ub, sa, sb, full, res;
        logic   c, o;
        mod  = 64'sd1 << w;
        half = mod / 2;
        ua   = longint'(av) & (mod - 1);
        ub   = longint'(bv) & (mod - 1);
        sa   = (ua >= half) ? ua - mod : ua;
        sb   = (ub >= half) ? ub - mod : ub;
        if (subv) begin
            full = ua - ub;
            c    = (ua >= ub);
            res  = sa - sb;
        end else begin
            full = ua + ub;
            c    = (full >= mod);
            res  = sa + sb;
        end
        o    = (res < -half) || (res >= half);
        full = full & (mod - 1);
        return {full[15:0], c, o};
    endfunction

    always @(negedge clk) begin
        entry_t e;
        if (rst_n && done8) begin
            done8_cnt++;
            if (q8.size() == 0) begin
                check("done8_unexpected", 64'(done8), 64'(0));
            end else begin
                e = q8.pop_front();
                check("result8", {46'd0, 8'h00, s8, co8, ov8}, {46'd0, e.exp});
                check("latency8", 64'(cyc - e.issue_cyc), 64'(9));
                check("ready_busy8", {62'd0, ready8, busy8}, 64'b10);
            end
        end
        if (rst_n && done16) begin
            if (q16.size() == 0) begin
                check("done16_unexpected", 64'(done16), 64'(0));
            end else begin
                e = q16.pop_front();
                check("result16", {46'd0, s16, co16, ov16}, {46'd0, e.exp});
                check("latency16", 64'(cyc - e.issue_cyc), 64'(5));
            end
        end
    end

    // Call at a negedge; waits for ready, pulses start for one cycle, then scrambles inputs.
    task automatic issue(input bit w16, input logic [15:0] av, input logic [15:0] bv,
                         input logic subv);
        entry_t e;
        int     guard = 0;
        while (!(w16 ? ready16 : ready8)) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                check("ready_timeout", 64'(0), 64'(1));
                return;
            end
        end
        a   = av;
        b   = bv;
        sub = subv;
        e.exp       = ref_op(w16 ? 16 : 8, av, bv, subv);
        e.issue_cyc = cyc;
        if (w16) begin
            start16 = 1'b1;
            q16.push_back(e);
        end else begin
            start8 = 1'b1;
            q8.push_back(e);
        end
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_done8();
        int guard = 0;
        while (!done8 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("done8_timeout", 64'(done8), 64'(1));
    endtask

    task automatic drain(input bit w16);
        int guard = 0;
        while ((w16 ? q16.size() : q8.size()) != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check(w16 ? "drain16" : "drain8", 64'(w16 ? q16.size() : q8.size()), 64'(0));
    endtask

    initial begin
        int snap;
        start8  = 1'b0;
        start16 = 1'b0;
        sub     = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clk);
        check("reset8_ctl", {59'd0, ready8, busy8, done8, co8, ov8}, 64'b10000);
        check("reset8_s", 64'(s8), 64'(0));
        check("reset16_ctl", {59'd0, ready16, busy16, done16, co16, ov16}, 64'b10000);
        check("reset16_s", 64'(s16), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed 8-bit cases
        issue(0, 16'h0F, 16'h01, 1'b0);
        issue(0, 16'hFF, 16'h01, 1'b0);
        issue(0, 16'h7F, 16'h01, 1'b0);
        issue(0, 16'h05, 16'h07, 1'b1);
        issue(0, 16'h80, 16'h01, 1'b1);

        // start while busy must be ignored
        issue(0, 16'h01, 16'h02, 1'b0);
        repeat (2) @(negedge clk);
        a      = 16'h11;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;

        // Start accepted in the done cycle; done drops the next cycle
        wait_done8();
        issue(0, 16'h21, 16'h13, 1'b0);
        check("b2b_done_drop", {62'd0, done8, busy8}, 64'b01);
        drain(0);

        // Asynchronous reset mid-operation aborts without a done pulse
        issue(0, 16'h33, 16'h44, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctl", {61'd0, ready8, busy8, done8}, 64'b100);
        check("abort_s", 64'(s8), 64'(0));
        q8.delete();
        snap = done8_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", 64'(done8_cnt), 64'(snap));
        issue(0, 16'h5A, 16'h26, 1'b0);
        drain(0);

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1000; i++) begin
                issue(0, 16'($urandom_range(255)), 16'($urandom_range(255)), 1'(m));
            end
        end
        drain(0);

        // 16-bit, 4-bit digits
        issue(1, 16'hFFFF, 16'h0001, 1'b0);
        issue(1, 16'h8000, 16'h0001, 1'b1);
        issue(1, 16'h1234, 16'h4321, 1'b1);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1000; i++) begin
                issue(1, 16'($urandom), 16'($urandom), 1'(m));
            end
        end
        drain(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
